uart_wb_stream_bridge: RTL and testbench

- Wishbone master sitting directly upstream of uart_top, in place of the bench bus master.
- After reset it programs the UART: LCR with DLAB set, DL1, DL2, LCR restored, FCR, IER.
- It then moves bytes from a valid/ready TX stream into the THR.
- It drains received bytes from the RBR into a valid/ready RX stream, using LSR polling only (no interrupt dependency).

---
 rtl/uart_wb_stream_bridge.sv | 188 ++++++++++++++++++
 tb/tb_uart_wb_stream_bridge.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_stream_bridge.sv
// Wishbone master for uart_top: programs the UART after reset, then moves bytes
// from a TX stream into the THR and from the RBR into an RX stream by LSR polling.
module uart_wb_stream_bridge #(
    parameter logic [15:0] DIVISOR  = 16'd2,
    parameter logic [7:0]  LCR_VAL  = 8'h1B,
    parameter logic [7:0]  FCR_VAL  = 8'h07,
    parameter logic [7:0]  IER_VAL  = 8'h00,
    parameter int unsigned TX_BURST = 16
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    output logic [4:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        tx_ready_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        cfg_done_o
);
    localparam int unsigned BCW = 5;
    localparam logic [4:0] ADR_DAT = 5'd0;
    localparam logic [4:0] ADR_IER = 5'd1;
    localparam logic [4:0] ADR_FCR = 5'd2;
    localparam logic [4:0] ADR_LCR = 5'd3;
    localparam logic [4:0] ADR_LSR = 5'd5;

    typedef enum logic [3:0] {
        CFG_LCR_DLAB, CFG_DL1, CFG_DL2, CFG_LCR, CFG_FCR, CFG_IER,
        POLL, RX_RD, TX_WAIT, TX_WR
    } state_t;

    state_t         state, state_d;
    logic [BCW-1:0] burst_cnt, burst_d;
    logic [7:0]     tx_byte, tx_byte_d;
    logic [4:0]     adr_d;
    logic [31:0]    dat_d;
    logic [3:0]     sel_d;
    logic           we_d, cyc_d, stb_d, tx_ready_d, rx_valid_d, cfg_done_d;
    logic [7:0]     rx_data_d;
    logic           req_en, req_we, bus_done;
    logic [4:0]     req_adr;
    logic [7:0]     req_byte, rd_byte;

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= CFG_LCR_DLAB;
            burst_cnt  <= '0;
            tx_byte    <= '0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_sel_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            tx_ready_o <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            cfg_done_o <= 1'b0;
        end else begin
            state      <= state_d;
            burst_cnt  <= burst_d;
            tx_byte    <= tx_byte_d;
            wb_adr_o   <= adr_d;
            wb_dat_o   <= dat_d;
            wb_sel_o   <= sel_d;
            wb_we_o    <= we_d;
            wb_cyc_o   <= cyc_d;
            wb_stb_o   <= stb_d;
            tx_ready_o <= tx_ready_d;
            rx_data_o  <= rx_data_d;
            rx_valid_o <= rx_valid_d;
            cfg_done_o <= cfg_done_d;
        end
    end

    always_comb begin
        state_d    = state;
        burst_d    = burst_cnt;
        tx_byte_d  = tx_byte;
        adr_d      = wb_adr_o;
        dat_d      = wb_dat_o;
        sel_d      = wb_sel_o;
        we_d       = wb_we_o;
        cyc_d      = wb_cyc_o;
        stb_d      = wb_stb_o;
        tx_ready_d = tx_ready_o;
        rx_data_d  = rx_data_o;
        rx_valid_d = rx_valid_o & ~rx_ready_i;
        cfg_done_d = cfg_done_o;
        req_en     = 1'b1;
        req_we     = 1'b0;
        req_adr    = ADR_DAT;
        req_byte   = 8'h00;
        bus_done   = wb_cyc_o & wb_ack_i;
        rd_byte    = wb_dat_i[{wb_adr_o[1:0], 3'b000} +: 8];

        // Register access owned by the current state
        case (state)
            CFG_LCR_DLAB: begin req_adr = ADR_LCR; req_we = 1'b1; req_byte = LCR_VAL | 8'h80; end
            CFG_DL1:      begin req_adr = ADR_DAT; req_we = 1'b1; req_byte = DIVISOR[7:0]; end
            CFG_DL2:      begin req_adr = ADR_IER; req_we = 1'b1; req_byte = DIVISOR[15:8]; end
            CFG_LCR:      begin req_adr = ADR_LCR; req_we = 1'b1; req_byte = LCR_VAL & 8'h7F; end
            CFG_FCR:      begin req_adr = ADR_FCR; req_we = 1'b1; req_byte = FCR_VAL; end
            CFG_IER:      begin req_adr = ADR_IER; req_we = 1'b1; req_byte = IER_VAL; end
            POLL:         req_adr = ADR_LSR;
            RX_RD:        req_adr = ADR_DAT;
            TX_WR:        begin req_adr = ADR_DAT; req_we = 1'b1; req_byte = tx_byte; end
            default:      req_en = 1'b0;
        endcase

        // Bus handshake: launch when idle, release for one cycle after ack
        if (bus_done) begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
            we_d  = 1'b0;
            adr_d = '0;
            sel_d = '0;
            dat_d = '0;
        end else if (req_en && !wb_cyc_o) begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            we_d  = req_we;
            adr_d = req_adr;
            sel_d = 4'(4'b0001 << req_adr[1:0]);
            dat_d = 32'(req_byte) << {req_adr[1:0], 3'b000};
        end

        case (state)
            CFG_LCR_DLAB: if (bus_done) state_d = CFG_DL1;
            CFG_DL1:      if (bus_done) state_d = CFG_DL2;
            CFG_DL2:      if (bus_done) state_d = CFG_LCR;
            CFG_LCR:      if (bus_done) state_d = CFG_FCR;
            CFG_FCR:      if (bus_done) state_d = CFG_IER;
            CFG_IER: begin
                if (bus_done) begin
                    state_d    = POLL;
                    cfg_done_d = 1'b1;
                end
            end
            POLL: begin
                if (bus_done) begin
                    if (rd_byte[0] && !rx_valid_o) begin
                        state_d = RX_RD;
                    end else if (rd_byte[5]) begin
                        burst_d = BCW'(TX_BURST);
                        state_d = TX_WAIT;
                    end else if (burst_cnt != '0 && tx_valid_i) begin
                        state_d = TX_WAIT;
                    end
                end
            end
            RX_RD: begin
                if (bus_done) begin
                    rx_data_d  = rd_byte;
                    rx_valid_d = 1'b1;
                    state_d    = POLL;
                end
            end
            TX_WAIT: begin
                if (!tx_valid_i) begin
                    tx_ready_d = 1'b0;
                    state_d    = POLL;
                end else if (tx_ready_o) begin
                    tx_byte_d  = tx_data_i;
                    tx_ready_d = 1'b0;
                    state_d    = TX_WR;
                end else begin
                    tx_ready_d = 1'b1;
                end
            end
            TX_WR: begin
                if (bus_done) begin
                    burst_d = (burst_cnt == '0) ? '0 : burst_cnt - BCW'(1);
                    state_d = POLL;
                end
            end
            default: state_d = CFG_LCR_DLAB;
        endcase
    end
endmodule

// File: tb/tb_uart_wb_stream_bridge.sv
// Bench for uart_wb_stream_bridge: a behavioural UART register slave plus a
// transaction-level model of the bridge's bus, stream and burst rules.
module tb_uart_wb_stream_bridge;
    localparam int TX_BURST = 16;
    localparam int E_ANY = 0, E_RBR = 1, E_LSR = 2;
    localparam int K_LSR = 0, K_RBR = 1, K_THR = 2, K_BAD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, rx_ready, cfg_done_o;

    uart_wb_stream_bridge dut (
        .clk(clk), .wb_rst_i(rst),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready),
        .cfg_done_o(cfg_done_o)
    );

    always #5 clk = ~clk;

    // UART slave state
    logic [7:0] rx_fifo[$];
    int         thre_mode = 0;
    logic       shot_used;
    logic       thre_v;

    // Bench/model state (owned by the main process)
    int          checks = 0, fails = 0;
    logic [7:0]  tx_mem [0:1023];
    int          tx_target = 0, tx_acc = 0, tx_cur = 0;
    bit          tx_fast = 0;
    int          rx_mode = 0, rx_target = 0, rx_inj = 0, rx_pushed = 0, rx_consumed = 0;
    int          ntx = 0, credits = 0, expect_next = E_LSR;
    int          thr_total = 0, thr_since_thre = 0, rbr_reads = 0;
    bit          rx_held = 0;
    logic [7:0]  rx_byte = 8'h00;
    logic [7:0]  exp_thr[$];
    bit          prev_done = 0, prev_cyc = 0;
    logic [31:0] prev_dat = '0;
    logic [9:0]  prev_ctl = '0;

    logic [4:0]  cfg_adr [6] = '{5'd3, 5'd0, 5'd1, 5'd3, 5'd2, 5'd1};
    logic [3:0]  cfg_sel [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0100, 4'b0010};
    logic [31:0] cfg_dat [6] = '{32'h9B000000, 32'h00000002, 32'h00000000,
                                 32'h1B000000, 32'h00070000, 32'h00000000};

    // Slave acks one cycle after strobe; unused read lanes carry junk
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_i  <= 1'b0;
            wb_dat_i  <= '0;
            shot_used <= 1'b0;
        end else begin
            wb_ack_i <= wb_cyc_o & wb_stb_o & ~wb_ack_i;
            if (thre_mode != 3) shot_used <= 1'b0;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_we_o) begin
                if (wb_adr_o == 5'd5) begin
                    case (thre_mode)
                        1:       thre_v = 1'b1;
                        2:       thre_v = ($urandom % 4) == 0;
                        3:       thre_v = !shot_used;
                        default: thre_v = 1'b0;
                    endcase
                    if (thre_mode == 3) shot_used <= 1'b1;
                    wb_dat_i <= {16'h0000, 2'b00, thre_v, 4'b0000, rx_fifo.size() != 0, 8'hFF};
                end else if (wb_adr_o == 5'd0) begin
                    wb_dat_i <= {16'hC33C, 8'hFF, (rx_fifo.size() != 0) ? rx_fifo[0] : 8'h00};
                end else begin
                    wb_dat_i <= 32'hDEADBEEF;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic monitor();
        bit done, full_now;
        int kind, want;
        logic [7:0] lsr;
        if (rst) begin
            chk("rst_dat", wb_dat_o, 32'h0);
            chk("rst_ctl", 32'({wb_adr_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
                                tx_ready_o, rx_valid_o, cfg_done_o, rx_data_o}), 32'h0);
            ntx = 0; credits = 0; rx_held = 0; exp_thr.delete();
            expect_next = E_LSR; prev_done = 0; prev_cyc = 0;
            return;
        end
        chk("stb_eq_cyc", 32'(wb_stb_o), 32'(wb_cyc_o));
        if (prev_done) chk("cyc_drop_after_ack", 32'(wb_cyc_o), 32'h0);
        else if (prev_cyc && wb_cyc_o) begin
            chk("hold_dat", wb_dat_o, prev_dat);
            chk("hold_ctl", 32'({wb_adr_o, wb_sel_o, wb_we_o}), 32'(prev_ctl));
        end
        if (tx_ready_o) chk("ready_only_idle_cfg", 32'({cfg_done_o, wb_cyc_o}), 32'h2);
        chk("cfg_done", 32'(cfg_done_o), 32'(ntx >= 6));
        chk("rx_valid", 32'(rx_valid_o), 32'(rx_held));
        if (rx_held) chk("rx_data", 32'(rx_data_o), 32'(rx_byte));

        full_now = rx_held;
        if (rx_held && rx_ready) begin rx_held = 0; rx_consumed++; end
        if (tx_valid && tx_ready_o) begin exp_thr.push_back(tx_data); tx_acc++; end

        done = wb_cyc_o && wb_stb_o && wb_ack_i;
        if (done) begin
            if (ntx < 6) begin
                chk("cfg_adr", 32'(wb_adr_o), 32'(cfg_adr[ntx]));
                chk("cfg_sel", 32'(wb_sel_o), 32'(cfg_sel[ntx]));
                chk("cfg_dat", wb_dat_o, cfg_dat[ntx]);
                chk("cfg_we", 32'(wb_we_o), 32'h1);
                if (ntx == 5) expect_next = E_LSR;
            end else begin
                if (!wb_we_o && wb_adr_o == 5'd5)      kind = K_LSR;
                else if (!wb_we_o && wb_adr_o == 5'd0) kind = K_RBR;
                else if (wb_we_o && wb_adr_o == 5'd0)  kind = K_THR;
                else                                   kind = K_BAD;
                if (expect_next == E_RBR)      want = K_RBR;
                else if (expect_next == E_LSR) want = K_LSR;
                else                           want = (kind == K_THR) ? K_THR : K_LSR;
                chk("next_access", 32'(kind), 32'(want));
                chk("sel_lane", 32'(wb_sel_o), 32'(4'b0001 << wb_adr_o[1:0]));
                if (kind == K_LSR) begin
                    lsr = wb_dat_i[15:8];
                    if (lsr[5]) begin credits = TX_BURST; thr_since_thre = 0; end
                    if (lsr[0] && !full_now)                   expect_next = E_RBR;
                    else if (lsr[5] || (credits > 0 && tx_valid)) expect_next = E_ANY;
                    else                                       expect_next = E_LSR;
                end else if (kind == K_RBR) begin
                    chk("rbr_has_data", 32'(rx_fifo.size() != 0), 32'h1);
                    if (rx_fifo.size() != 0) begin
                        rx_byte = rx_fifo.pop_front();
                        rx_held = 1;
                    end
                    rbr_reads++;
                    expect_next = E_LSR;
                end else if (kind == K_THR) begin
                    chk("thr_within_burst", 32'(credits > 0), 32'h1);
                    chk("thr_has_byte", 32'(exp_thr.size() != 0), 32'h1);
                    if (exp_thr.size() != 0) chk("thr_data", wb_dat_o, {24'h0, exp_thr.pop_front()});
                    if (credits > 0) credits--;
                    thr_total++;
                    thr_since_thre++;
                    expect_next = E_LSR;
                end
            end
            ntx++;
        end
        prev_done = done;
        prev_cyc  = wb_cyc_o;
        prev_dat  = wb_dat_o;
        prev_ctl  = {wb_adr_o, wb_sel_o, wb_we_o};
    endtask

    task automatic drive();
        if (tx_valid && tx_acc > tx_cur) tx_valid = 1'b0;
        if (!tx_valid && tx_acc < tx_target && (tx_fast || ($urandom % 4) != 0)) begin
            tx_cur   = tx_acc;
            tx_data  = tx_mem[tx_cur];
            tx_valid = 1'b1;
        end
        case (rx_mode)
            1:       rx_ready = ($urandom % 3) == 0;
            2:       rx_ready = 1'b1;
            default: rx_ready = 1'b0;
        endcase
        if (rx_inj < rx_target && ($urandom % 16) == 0) begin
            rx_fifo.push_back(8'($urandom));
            rx_inj++;
            rx_pushed++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_fifo.push_back(b);
        rx_pushed++;
    endtask

    initial begin
        int n, base;
        tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        for (int i = 0; i < 1024; i++) tx_mem[i] = 8'($urandom);
        repeat (3) step();
        rst = 1'b0;

        // Configuration sequence
        n = 0; while (ntx < 7 && n < 300) begin step(); n++; end
        chk("cfg_wait", 32'(ntx >= 7), 32'h1);
        chk("cfg_done_high", 32'(cfg_done_o), 32'h1);

        // Two received bytes, each held until consumed
        push_rx(8'h81); push_rx(8'h42);
        n = 0; while (!rx_valid_o && n < 200) begin step(); n++; end
        repeat (30) step();
        chk("rx_first_valid", 32'(rx_valid_o), 32'h1);
        chk("rx_first_byte", 32'(rx_data_o), 32'h81);
        rx_mode = 2; step(); rx_mode = 0; step();
        n = 0; while (!rx_valid_o && n < 200) begin step(); n++; end
        repeat (10) step();
        chk("rx_second_byte", 32'({rx_valid_o, rx_data_o}), 32'h142);
        rx_mode = 2;
        n = 0; while (rx_held && n < 100) begin step(); n++; end

        // Back-pressure: DR stays high, only one RBR read while full
        rx_mode = 0;
        push_rx(8'h11); push_rx(8'h22); push_rx(8'h33);
        base = rbr_reads;
        repeat (200) step();
        chk("bp_single_read", 32'(rbr_reads - base), 32'h1);
        chk("bp_held", 32'(rx_valid_o), 32'h1);
        rx_mode = 2;
        n = 0; while ((rx_held || rx_fifo.size() != 0) && n < 500) begin step(); n++; end
        chk("bp_drain", 32'(rx_held || rx_fifo.size() != 0), 32'h0);

        // Burst limit: one THRE, twenty bytes queued
        base = thr_total;
        tx_fast = 1; thre_mode = 3; tx_target += 20;
        repeat (600) step();
        chk("burst_writes", 32'(thr_total - base), 32'd16);
        chk("burst_since_thre", 32'(thr_since_thre), 32'd16);
        thre_mode = 1;
        n = 0; while (thr_total < tx_target && n < 600) begin step(); n++; end
        chk("burst_rest", 32'(thr_total - base), 32'd20);

        // DR and THRE together with TX pending: RBR read must come first
        push_rx(8'hA7); tx_target += 3;
        n = 0; while ((thr_total < tx_target || rx_held || rx_fifo.size() != 0) && n < 600) begin
            step(); n++;
        end
        chk("prio_drain", 32'(thr_total), 32'(tx_target));

        // Randomized traffic
        tx_fast = 0; thre_mode = 2; rx_mode = 1;
        rx_target += 40; tx_target += 60;
        n = 0;
        while ((thr_total < tx_target || rx_inj < rx_target || rx_fifo.size() != 0 || rx_held)
               && n < 30000) begin
            step(); n++;
        end
        chk("random_tx_done", 32'(thr_total), 32'(tx_target));
        chk("random_rx_done", 32'(rx_consumed), 32'(rx_pushed));

        // Reset while the THR write strobe is up
        thre_mode = 1; tx_fast = 1; tx_target += 1;
        base = thr_total;
        n = 0; while (!(wb_stb_o && wb_we_o && wb_adr_o == 5'd0) && n < 300) begin step(); n++; end
        chk("thr_strobe_seen", 32'(wb_stb_o && wb_we_o), 32'h1);
        #2 rst = 1'b1;
        #1 chk("rst_drops_bus", 32'({wb_cyc_o, wb_stb_o}), 32'h0);
        repeat (3) step();
        rst = 1'b0;
        n = 0; while (ntx < 7 && n < 300) begin step(); n++; end
        chk("recfg_wait", 32'(ntx >= 7), 32'h1);
        repeat (150) step();
        chk("pending_discarded", 32'(thr_total - base), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
